// File: rtl/calc_operand_sequencer.sv
// Front-end sequencer for the 4-bit calculator: collects A, B and opcode from the switch bank,
// holds them on the ALU bus for SETTLE cycles, then captures the ALU result for display and chaining.
module calc_operand_sequencer #(
  parameter int SETTLE = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] sw,
  input  logic       btn_enter,
  input  logic       btn_clear,
  input  logic [3:0] alu_result,
  input  logic       alu_overflow,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [3:0] alu_opcode,
  output logic       alu_reset,
  output logic [3:0] result_q,
  output logic       ovf_q,
  output logic       err_q,
  output logic       done,
  output logic [2:0] state_q
);

  localparam logic [2:0] S_A    = 3'd0;
  localparam logic [2:0] S_B    = 3'd1;
  localparam logic [2:0] S_OP   = 3'd2;
  localparam logic [2:0] S_EXEC = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

  logic       btn_d;
  logic       press;
  logic [3:0] cnt;

  // Opcodes 1101..1111 are undefined; 1001 with a zero B operand is a divide-by-zero.
  function automatic logic is_reject(input logic [3:0] op, input logic [3:0] b);
    return (op == 4'b1101) || (op == 4'b1110) || (op == 4'b1111) ||
           ((op == 4'b1001) && (b == 4'd0));
  endfunction

  assign press     = btn_enter & ~btn_d;
  assign alu_reset = (state_q == S_A);

  // Edge detector keeps sampling through clear so a button held across clear is not a new press.
  always_ff @(posedge clk) begin
    if (reset) btn_d <= 1'b0;
    else       btn_d <= btn_enter;
  end

  always_ff @(posedge clk) begin
    if (reset || btn_clear) begin
      state_q    <= S_A;
      alu_a      <= 4'd0;
      alu_b      <= 4'd0;
      alu_opcode <= 4'd0;
      result_q   <= 4'd0;
      ovf_q      <= 1'b0;
      err_q      <= 1'b0;
      done       <= 1'b0;
      cnt        <= 4'd0;
    end else begin
      done <= 1'b0;
      case (state_q)
        S_A: begin
          if (press) begin
            alu_a   <= sw;
            state_q <= S_B;
          end
        end
        S_B: begin
          if (press) begin
            alu_b   <= sw;
            state_q <= S_OP;
          end
        end
        S_OP: begin
          if (press) begin
            alu_opcode <= sw;
            if (is_reject(sw, alu_b)) begin
              err_q    <= 1'b1;
              result_q <= 4'd0;
              ovf_q    <= 1'b0;
              done     <= 1'b1;
              state_q  <= S_DONE;
            end else begin
              cnt     <= CNT_INIT;
              state_q <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          if (cnt == 4'd0) begin
            result_q <= alu_result;
            ovf_q    <= alu_overflow;
            err_q    <= 1'b0;
            done     <= 1'b1;
            state_q  <= S_DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_DONE: begin
          if (press) begin
            if (!err_q) begin
              alu_a   <= result_q;
              ovf_q   <= 1'b0;
              state_q <= S_B;
            end else begin
              err_q   <= 1'b0;
              state_q <= S_A;
            end
          end
        end
        default: state_q <= S_A;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_operand_sequencer.sv
// Bench for calc_operand_sequencer: directed button sequences, a small ALU model on the bus,
// and a scoreboard that pairs every done pulse with the expected capture.
module tb_calc_operand_sequencer;

  localparam int SETTLE = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] sw;
  logic       btn_enter;
  logic       btn_clear;
  logic [3:0] alu_result;
  logic       alu_overflow;
  logic [3:0] alu_a, alu_b, alu_opcode;
  logic       alu_reset;
  logic [3:0] result_q;
  logic       ovf_q, err_q, done;
  logic [2:0] state_q;

  calc_operand_sequencer #(.SETTLE(SETTLE)) dut (
    .clk(clk), .reset(reset), .sw(sw), .btn_enter(btn_enter), .btn_clear(btn_clear),
    .alu_result(alu_result), .alu_overflow(alu_overflow),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_reset(alu_reset),
    .result_q(result_q), .ovf_q(ovf_q), .err_q(err_q), .done(done), .state_q(state_q)
  );

  always #5 clk = ~clk;

  // Stand-in ALU: 0010 subtract (borrow), 0011 add (carry), 0100 multiply (product > 15).
  always_comb begin
    logic [7:0] wide;
    wide         = 8'd0;
    alu_result   = 4'd0;
    alu_overflow = 1'b0;
    case (alu_opcode)
      4'b0010: begin wide = {4'd0, alu_a} - {4'd0, alu_b}; alu_result = wide[3:0]; alu_overflow = wide[7]; end
      4'b0011: begin wide = {4'd0, alu_a} + {4'd0, alu_b}; alu_result = wide[3:0]; alu_overflow = wide[4]; end
      4'b0100: begin wide = alu_a * alu_b; alu_result = wide[3:0]; alu_overflow = (wide > 8'd15); end
      default: ;
    endcase
  end

  typedef struct {
    logic [3:0] res;
    logic       ovf;
    logic       err;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest expected capture, including its cycle.
  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("done_result", int'(result_q), int'(e.res));
        chk("done_ovf", int'(ovf_q), int'(e.ovf));
        chk("done_err", int'(err_q), int'(e.err));
        chk("done_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic press(input logic [3:0] v);
    sw = v;
    btn_enter = 1'b1;
    @(posedge clk); #1;
    btn_enter = 1'b0;
    @(posedge clk); #1;
  endtask

  // The press edge is the next edge; an accepted op lands done SETTLE edges later.
  task automatic op_press(input logic [3:0] v, input logic [3:0] res, input logic ovf,
                          input logic err);
    exp_t e;
    e.res = res; e.ovf = ovf; e.err = err;
    e.cyc = cyc + 1 + (err ? 0 : SETTLE);
    exp_q.push_back(e);
    press(v);
  endtask

  task automatic wait_done();
    int n = 0;
    while (exp_q.size() != 0 && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("done_timeout", 0, 1);
      exp_q.delete();
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_state"}, int'(state_q), 0);
    chk({tag, "_alu_reset"}, int'(alu_reset), 1);
    chk({tag, "_alu_a"}, int'(alu_a), 0);
    chk({tag, "_alu_b"}, int'(alu_b), 0);
    chk({tag, "_opcode"}, int'(alu_opcode), 0);
    chk({tag, "_result"}, int'(result_q), 0);
    chk({tag, "_ovf"}, int'(ovf_q), 0);
    chk({tag, "_err"}, int'(err_q), 0);
    chk({tag, "_done"}, int'(done), 0);
  endtask

  initial begin
    reset = 1'b1; sw = 4'd0; btn_enter = 1'b0; btn_clear = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk_idle("reset");

    // Add 7 + 5
    press(4'd7);
    chk("add_a", int'(alu_a), 7);
    chk("add_state_b", int'(state_q), 1);
    chk("add_alu_reset", int'(alu_reset), 0);
    press(4'd5);
    chk("add_b", int'(alu_b), 5);
    chk("add_state_op", int'(state_q), 2);
    op_press(4'b0011, 4'b1100, 1'b0, 1'b0);
    chk("add_exec", int'(state_q), 3);
    wait_done();
    chk("add_state_done", int'(state_q), 4);
    chk("add_opcode", int'(alu_opcode), 3);
    chk("add_done_low", int'(done), 0);

    // Clear, then overflow passthrough 15 + 1 and a chain press
    btn_clear = 1'b1;
    @(posedge clk); #1;
    btn_clear = 1'b0;
    chk_idle("clear");
    press(4'b1111);
    press(4'b0001);
    op_press(4'b0011, 4'b0000, 1'b1, 1'b0);
    wait_done();
    press(4'b0110);
    chk("ovf_chain_a", int'(alu_a), 0);
    chk("ovf_chain_ovf", int'(ovf_q), 0);
    chk("ovf_chain_state", int'(state_q), 1);

    // Divide by zero rejected
    press(4'b0000);
    op_press(4'b1001, 4'b0000, 1'b0, 1'b1);
    wait_done();
    chk("div0_state", int'(state_q), 4);
    chk("div0_opcode", int'(alu_opcode), 9);
    press(4'b0000);
    chk("div0_back_state", int'(state_q), 0);
    chk("div0_back_err", int'(err_q), 0);

    // Chain: 3 * 4 = 12, then 12 - 2 = 10
    press(4'd3);
    press(4'd4);
    op_press(4'b0100, 4'b1100, 1'b0, 1'b0);
    wait_done();
    press(4'd0);
    chk("chain_a", int'(alu_a), 12);
    press(4'b0010);
    op_press(4'b0010, 4'b1010, 1'b0, 1'b0);
    wait_done();

    // Undefined opcode rejected after a nonzero result
    press(4'd0);
    chk("rej_chain_a", int'(alu_a), 10);
    press(4'd1);
    op_press(4'b1110, 4'b0000, 1'b0, 1'b1);
    wait_done();
    press(4'd0);
    chk("rej_back_state", int'(state_q), 0);

    // Held button: exactly one press
    sw = 4'd9;
    btn_enter = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("held_a", int'(alu_a), 9);
    chk("held_state", int'(state_q), 1);
    btn_enter = 1'b0;
    @(posedge clk); #1;
    press(4'd1);
    op_press(4'b0011, 4'b1010, 1'b0, 1'b0);
    // Press while still in S_EXEC must be ignored
    sw = 4'd5;
    btn_enter = 1'b1;
    @(posedge clk); #1;
    btn_enter = 1'b0;
    wait_done();
    chk("exec_press_state", int'(state_q), 4);
    chk("exec_press_a", int'(alu_a), 9);
    chk("exec_press_b", int'(alu_b), 1);

    // Clear and enter on the same edge inside S_EXEC aborts the op
    press(4'd0);
    press(4'd2);
    press(4'b0011);
    chk("abort_in_exec", int'(state_q), 3);
    btn_clear = 1'b1;
    btn_enter = 1'b1;
    sw = 4'd7;
    @(posedge clk); #1;
    btn_clear = 1'b0;
    btn_enter = 1'b0;
    chk_idle("abort");
    repeat (6) @(posedge clk);
    #1;

    // Synchronous reset mid-S_B
    press(4'd4);
    chk("rst_mid_state", int'(state_q), 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk_idle("rst_mid");
    repeat (4) @(posedge clk);
    #1;
    chk("leftover_expect", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/calc_operand_sequencer.md
# calc_operand_sequencer

Front-end controller for the 4-bit calculator datapath. It turns a 4-bit switch bank and debounced enter/clear buttons into the ALU's operand/opcode bus (A, B, Opcode, reset). After a programmable settle time it captures the ALU's Result/Overflow into display registers. Results can be chained: the last result becomes the next A.

## Interface
- SETTLE, default 2: cycles `alu_a/alu_b/alu_opcode` are held stable in EXEC before capture; legal range 1..15.
- clk  in  1  rising-edge clock
- reset  in  1  reset, synchronous, active-high
- sw  in  4  operand/opcode entry switches
- btn_enter  in  1  debounced, synchronous enter level
- btn_clear  in  1  debounced, synchronous clear level
- alu_result  in  4  ALU Result (combinational from alu_* outputs)
- alu_overflow  in  1  ALU Overflow
- alu_a  out  4  registered operand A
- alu_b  out  4  registered operand B
- alu_opcode  out  4  registered opcode
- alu_reset  out  1  high whenever state is S_A
- result_q  out  4  captured result
- ovf_q  out  1  captured overflow
- err_q  out  1  rejected operation flag
- done  out  1  one-cycle pulse on the first S_DONE cycle
- state_q  out  3  current state code, for display

## Operation
- Press detect: register `btn_d <= btn_enter` (reset 0); `press = btn_enter & ~btn_d`. A held button yields exactly one press. `btn_d` updates in every state.
- State codes: S_A=0, S_B=1, S_OP=2, S_EXEC=3, S_DONE=4. Codes 5-7 are unreachable and recover to S_A on the next cycle.
- Reset: state S_A; `alu_a`, `alu_b`, `alu_opcode`, `result_q`, `ovf_q`, `err_q`, `done`, settle counter and `btn_d` all 0. `alu_reset`=1.
- Clear: `btn_clear` level high has the same effect as reset on the next edge, except `btn_d`, which still samples. Clear beats a simultaneous press.
- S_A, on press: `alu_a<=sw`, go to S_B.
- S_B, on press: `alu_b<=sw`, go to S_OP.
- S_OP, on press: `alu_opcode<=sw`. The operation is rejected if `sw` is 1101, 1110 or 1111, or if `sw`==1001 and `alu_b`==0.
  - Rejected: go to S_DONE with `err_q=1`, `result_q=0`, `ovf_q=0`.
  - Accepted: load counter = SETTLE-1, go to S_EXEC.
- S_EXEC: presses are ignored. Counter decrements each cycle. On the cycle the counter is 0: `result_q<=alu_result`, `ovf_q<=alu_overflow`, `err_q<=0`, go to S_DONE.
- S_DONE: `done`=1 on the first cycle only. On press:
  - If `err_q`=0 (chain): `alu_a<=result_q`, `ovf_q<=0`, go to S_B.
  - If `err_q`=1: clear `err_q`, go to S_A.
- `result_q`, `ovf_q` and `err_q` hold their values until the next capture, reject, chain or clear.
- No arithmetic is done here. All 4-bit values pass through unchanged; the ALU owns overflow semantics.

## Timing
- All outputs are registered except `alu_reset`, which decodes `state_q`.
- Op press sampled at edge k. `alu_opcode` is valid after k; the block is in S_EXEC for cycles k+1..k+SETTLE.
- Capture happens at edge k+SETTLE. `done` is high during cycle k+SETTLE+1, i.e. latency SETTLE+1 edges from press to `done`.
- Rejected op: S_DONE and `done` follow edge k directly.
- The minimum spacing between accepted presses is 2 cycles, because the button must deassert for one sampled cycle.
- Reset or clear during S_EXEC aborts the operation: no capture, `done` stays 0.

## Test plan
- Add: A=7, B=5, op=0011 with SETTLE=2 → `done` 3 edges after op press; `result_q`=1100, `ovf_q`=0, `err_q`=0.
- Overflow passthrough: A=1111, B=0001, op=0011 → `result_q`/`ovf_q` equal the ALU model output (0000/1). A chain press then loads `alu_a`=0000 and clears `ovf_q`.
- Reject cases:
  - op=1001 with B=0 → `err_q`=1, `result_q`=0, no S_EXEC cycle; next press returns to S_A.
  - op=1110 → same response.
- Chain: 3×4 (op 0100) gives 1100; press, enter B=0010, op 0010 → `result_q`=1010.
- Held button for 10 cycles in S_A → only `alu_a` loaded, state=S_B. Presses during S_EXEC are ignored.
- Clear and enter asserted on the same edge in S_EXEC → S_A, all outputs 0, `done` never pulses. Synchronous reset mid-S_B gives the same result.
